// File: rtl/my_mult_sequencer.sv
// Multi-cycle signed WIDTH x WIDTH radix-2 Booth multiplier controller.
// All additions go through an external shared CLA adder; this block only sequences them.
module my_mult_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] acc_q, q_q, m_q, product_q;
  logic             qm1_q, ovf_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] b_sel, eff_sum, acc_nxt, q_nxt;
  logic             cin_sel, eff_cout, bypass, sign, run, last_step;

  assign run       = (state_q == StRun);
  assign last_step = (count_q == CNT_W'(WIDTH - 1));

  always_comb begin
    b_sel   = '0;
    cin_sel = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01: b_sel = m_q;
      2'b10: begin
        b_sel   = ~m_q;
        cin_sel = 1'b1;
      end
      default: ;
    endcase

    adder_a   = run ? acc_q : '0;
    adder_b   = run ? b_sel : '0;
    adder_cin = run ? cin_sel : 1'b0;

    // The shared adder outputs 0 for a=b=0 regardless of c_in, so rebuild that case locally.
    bypass   = (acc_q == '0) && (b_sel == '0);
    eff_sum  = bypass ? {{(WIDTH-1){1'b0}}, cin_sel} : adder_sum;
    eff_cout = bypass ? 1'b0 : adder_cout;

    // Bit 32 of the true sum keeps M = most-negative exact.
    sign    = acc_q[WIDTH-1] ^ b_sel[WIDTH-1] ^ eff_cout;
    acc_nxt = {sign, eff_sum[WIDTH-1:1]};
    q_nxt   = {eff_sum[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q   <= '0;
            q_q     <= multiplier;
            qm1_q   <= 1'b0;
            m_q     <= multiplicand;
            count_q <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_nxt;
          q_q     <= q_nxt;
          qm1_q   <= q_q[0];
          count_q <= count_q + CNT_W'(1);
          if (last_step) begin
            state_q   <= StDone;
            product_q <= q_nxt;
            ovf_q     <= (acc_nxt != {WIDTH{q_nxt[WIDTH-1]}});
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy         = run;
  assign result_valid = (state_q == StDone);
  assign product      = product_q;
  assign ovf          = ovf_q;

endmodule
